rc4_stream_core: RTL

//  Next-generation RC4 cipher core: runtime key length 1..MAX_KEY_BYTES, optional RC4-drop[N] discard.
//  Key, plaintext and ciphertext all move on valid/ready handshakes, so no fixed-timing byte feeders are needed.

---
 rtl/rc4_stream_core_if.sv | 35 +++
 rtl/rc4_stream_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_core_if.sv
// Handshake bundle for the RC4 stream core: control, key, plaintext and ciphertext channels.
// The core uses the slave modport; the key/plaintext source and ciphertext sink use master.
interface rc4_stream_core_if #(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_W        = 12,
  parameter int KW            = $clog2(MAX_KEY_BYTES + 1)
);
  logic              start;
  logic              stop;
  logic [KW-1:0]     key_size;
  logic [DROP_W-1:0] drop_n;
  logic              key_valid;
  logic [7:0]        key_byte;
  logic              key_ready;
  logic              plain_valid;
  logic [7:0]        plain_byte;
  logic              plain_ready;
  logic              enc_valid;
  logic [7:0]        enc_byte;
  logic              enc_ready;
  logic              busy;
  logic              error;

  modport master (
    output start, stop, key_size, drop_n, key_valid, key_byte,
           plain_valid, plain_byte, enc_ready,
    input  key_ready, plain_ready, enc_valid, enc_byte, busy, error
  );

  modport slave (
    input  start, stop, key_size, drop_n, key_valid, key_byte,
           plain_valid, plain_byte, enc_ready,
    output key_ready, plain_ready, enc_valid, enc_byte, busy, error
  );
endinterface

// File: rtl/rc4_stream_core.sv
// RC4 cipher core with runtime key length and optional RC4-drop[N] discard.
// One S-box swap per cycle in KSA, DROP and STREAM; ciphertext registered with 1-cycle latency.
module rc4_stream_core #(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_W        = 12,
  parameter int KW            = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rc4_stream_core_if.slave    bus_io
);
  localparam int KIW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KEY, ST_KSA, ST_DROP, ST_STREAM
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d;
  logic [KIW-1:0]    k_q, k_d;
  logic [KW-1:0]     len_q, len_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              enc_valid_q, enc_valid_d;
  logic [7:0]        enc_byte_q, enc_byte_d;
  logic              error_q, error_d;

  logic [7:0] s_q   [256];
  logic [7:0] key_q [MAX_KEY_BYTES];

  logic       ksa, k_last, key_acc, plain_rdy, plain_acc, swap_en;
  logic [7:0] ia, va, kb, jb, vb, t, ks;

  // Shared swap datapath: KSA indexes S[i], DROP/STREAM index S[i+1].
  assign ksa   = (state_q == ST_KSA);
  assign ia    = ksa ? i_q : i_q + 8'd1;
  assign va    = s_q[ia];
  assign kb    = ksa ? key_q[k_q] : 8'd0;
  assign jb    = j_q + va + kb;
  assign vb    = s_q[jb];
  assign t     = va + vb;
  // Keystream byte reads the post-swap S without waiting for the write.
  assign ks    = (t == ia) ? vb : (t == jb) ? va : s_q[t];

  assign k_last    = (KW'(k_q) == len_q - KW'(1));
  assign key_acc   = (state_q == ST_KEY) && bus_io.key_valid && !bus_io.stop;
  assign plain_rdy = (state_q == ST_STREAM) && (!enc_valid_q || bus_io.enc_ready);
  assign plain_acc = plain_rdy && bus_io.plain_valid && !bus_io.stop;
  assign swap_en   = !bus_io.stop && (ksa || state_q == ST_DROP || plain_acc);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    drop_d      = drop_q;
    enc_valid_d = enc_valid_q;
    enc_byte_d  = enc_byte_q;
    error_d     = 1'b0;
    if (bus_io.stop) begin
      state_d     = ST_IDLE;
      enc_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_io.start) begin
            if (bus_io.key_size == '0) begin
              error_d = 1'b1;
            end else begin
              len_d   = (bus_io.key_size > KW'(MAX_KEY_BYTES)) ? KW'(MAX_KEY_BYTES)
                                                               : bus_io.key_size;
              drop_d  = bus_io.drop_n;
              state_d = ST_INIT;
            end
          end
        end
        ST_INIT: begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = ST_KEY;
        end
        ST_KEY: begin
          if (key_acc) begin
            k_d = k_last ? '0 : k_q + 1'b1;
            if (k_last) state_d = ST_KSA;
          end
        end
        ST_KSA: begin
          i_d = i_q + 8'd1;
          j_d = jb;
          k_d = k_last ? '0 : k_q + 1'b1;
          if (i_q == 8'hFF) begin
            j_d     = 8'd0;
            state_d = (drop_q != '0) ? ST_DROP : ST_STREAM;
          end
        end
        ST_DROP: begin
          i_d    = ia;
          j_d    = jb;
          drop_d = drop_q - 1'b1;
          if (drop_q == DROP_W'(1)) state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (plain_acc) begin
            i_d         = ia;
            j_d         = jb;
            enc_byte_d  = bus_io.plain_byte ^ ks;
            enc_valid_d = 1'b1;
          end else if (bus_io.enc_ready) begin
            enc_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= '0;
      len_q       <= '0;
      drop_q      <= '0;
      enc_valid_q <= 1'b0;
      enc_byte_q  <= 8'h00;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      drop_q      <= drop_d;
      enc_valid_q <= enc_valid_d;
      enc_byte_q  <= enc_byte_d;
      error_q     <= error_d;
    end
  end

  // S and K carry no reset: INIT rewrites S and KEY_LOAD refills K before use.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      for (int n = 0; n < 256; n++) s_q[n] <= 8'(n);
    end else if (swap_en) begin
      s_q[ia] <= vb;
      s_q[jb] <= va;
    end
  end

  always_ff @(posedge clk_i) begin
    if (key_acc) key_q[k_q] <= bus_io.key_byte;
  end

  assign bus_io.key_ready   = (state_q == ST_KEY);
  assign bus_io.plain_ready = plain_rdy;
  assign bus_io.enc_valid   = enc_valid_q;
  assign bus_io.enc_byte    = enc_byte_q;
  assign bus_io.busy        = (state_q != ST_IDLE);
  assign bus_io.error       = error_q;
endmodule
